// File: rtl/multiword_shift_r_pkg.sv
// rtl/multiword_shift_r_pkg.sv - shared types for the multi-word right shifter
// Purpose: shift-type and sequencer-state enumerations used by
//          multiword_shift_r and its single-word datapath polyshift_r.
// Ports:   none (package).
package multiword_shift_r_pkg;

    typedef enum logic [1:0] {
        LOGIC = 2'd0,
        ARITH = 2'd1,
        RCR   = 2'd2,
        ROR   = 2'd3
    } shift_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REDUCE = 2'd2,
        EMIT   = 2'd3
    } mws_state_t;

endpackage

// File: rtl/polyshift_r.sv
// rtl/polyshift_r.sv - single-word right shifter (logic/arith/carry-rotate/rotate)
// Purpose: shifts one word right by 0..WORD_WIDTH-1 bits; the vacated upper
//          bits come from zero, the sign bit, the carry-in word c_i, or the
//          word itself depending on shift_type_i.
// Ports:   data_i        word to shift
//          c_i           bits entering from above the MSB (RCR mode)
//          shift_size_i  shift distance in bits
//          shift_type_i  LOGIC / ARITH / RCR / ROR
//          data_o        shifted word
module polyshift_r
    import multiword_shift_r_pkg::*;
#(
    parameter  int WORD_WIDTH = 8,
    localparam int SW         = $clog2(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic [WORD_WIDTH-2:0] c_i,
    input  logic [SW-1:0]         shift_size_i,
    input  shift_type_t           shift_type_i,
    output logic [WORD_WIDTH-1:0] data_o
);

    // The word with its WORD_WIDTH-1 possible incoming bits stacked on top;
    // shifting right by at most WORD_WIDTH-1 never needs more than that.
    logic [2*WORD_WIDTH-2:0] ext;

    always_comb begin
        ext = '0;
        case (shift_type_i)
            LOGIC:   ext = {{(WORD_WIDTH-1){1'b0}}, data_i};
            ARITH:   ext = {{(WORD_WIDTH-1){data_i[WORD_WIDTH-1]}}, data_i};
            RCR:     ext = {c_i, data_i};
            ROR:     ext = {data_i[WORD_WIDTH-2:0], data_i};
            default: ext = '0;
        endcase
    end

    assign data_o = WORD_WIDTH'(ext >> shift_size_i);

endmodule

// File: rtl/multiword_shift_r.sv
// rtl/multiword_shift_r.sv - sequenced multi-word right shifter
// Purpose: accepts a command (length, amount, type, fill), buffers LEN operand
//          words least-significant first, then streams LEN shifted words out
//          through one polyshift_r configured for carry-rotate.
// Ports:   clk_i, rst_i                 clock, async active-high reset
//          cmd_valid_i/cmd_ready_o      command handshake (IDLE only)
//          cmd_len_i/amount/type/fill   command fields, captured on handshake
//          in_valid_i/in_ready_o/in_data_i      operand stream (LOAD only)
//          out_valid_o/out_ready_i/out_data_o/out_last_o  result stream (EMIT)
//          busy_o                       sequencer not idle
module multiword_shift_r
    import multiword_shift_r_pkg::*;
#(
    parameter  int WORD_WIDTH = 8,
    parameter  int MAX_WORDS  = 4,
    localparam int AMT_W      = $clog2(MAX_WORDS*WORD_WIDTH),
    localparam int LEN_W      = $clog2(MAX_WORDS+1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic [AMT_W-1:0]      cmd_amount_i,
    input  shift_type_t           cmd_type_i,
    input  logic [WORD_WIDTH-1:0] cmd_fill_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int SW     = $clog2(WORD_WIDTH);
    localparam int BW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int IDX_W  = $clog2(2*MAX_WORDS);
    localparam int SPAN_W = AMT_W + 1;
    localparam int K_W    = AMT_W - SW;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    mws_state_t            state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [AMT_W-1:0]      amount_q;
    shift_type_t           type_q;
    logic [WORD_WIDTH-1:0] fill_q;
    logic [WORD_WIDTH-1:0] word_buf [MAX_WORDS];

    // Operand size in bits; one bit wider than the amount so a full-width
    // operand (MAX_WORDS*WORD_WIDTH) is representable.
    logic [SPAN_W-1:0] span;
    logic [SPAN_W-1:0] amount_ext;
    logic [SPAN_W-1:0] amount_red;
    logic              last_idx;

    assign span       = SPAN_W'(len_q) << SW;
    assign amount_ext = {1'b0, amount_q};
    assign amount_red = amount_ext - span;
    assign last_idx   = (cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            amount_q <= '0;
            type_q   <= LOGIC;
            fill_q   <= '0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                word_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A zero-length command is consumed without leaving IDLE.
                    if (cmd_valid_i && (cmd_len_i != '0)) begin
                        len_q    <= (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;
                        amount_q <= cmd_amount_i;
                        type_q   <= cmd_type_i;
                        fill_q   <= cmd_fill_i;
                        cnt_q    <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        word_buf[BW'(cnt_q)] <= in_data_i;
                        if (last_idx) begin
                            cnt_q <= '0;
                            // Rotation by a whole operand or more is folded
                            // back into range before emitting.
                            state <= (type_q == ROR && amount_ext >= span) ? REDUCE : EMIT;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                REDUCE: begin
                    amount_q <= amount_red[AMT_W-1:0];
                    if (amount_red < span) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        if (last_idx) begin
                            cnt_q <= '0;
                            state <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand extended upward to 2*MAX_WORDS words: the buffered words, then
    // whatever the shift type says enters from above the MSW.
    logic [WORD_WIDTH-1:0] ext_word [2*MAX_WORDS];
    logic                  sign_bit;
    logic [K_W-1:0]        k;
    logic [SW-1:0]         s;
    logic [IDX_W-1:0]      idx_lo;
    logic [IDX_W-1:0]      idx_hi;
    logic [WORD_WIDTH-1:0] shift_data;

    assign k        = amount_q[AMT_W-1:SW];
    assign s        = amount_q[SW-1:0];
    assign sign_bit = word_buf[BW'(len_q - LEN_W'(1))][WORD_WIDTH-1];
    assign idx_lo   = IDX_W'(cnt_q) + IDX_W'(k);
    assign idx_hi   = idx_lo + IDX_W'(1);

    always_comb begin
        for (int j = 0; j < 2*MAX_WORDS; j++) begin
            ext_word[j] = '0;
            if (j < int'(len_q)) begin
                ext_word[j] = word_buf[BW'(j)];
            end else begin
                case (type_q)
                    LOGIC:   ext_word[j] = '0;
                    ARITH:   ext_word[j] = {WORD_WIDTH{sign_bit}};
                    RCR:     ext_word[j] = fill_q;
                    ROR:     ext_word[j] = word_buf[BW'(j - int'(len_q))];
                    default: ext_word[j] = '0;
                endcase
            end
        end
    end

    polyshift_r #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_shift (
        .data_i       (ext_word[idx_lo]),
        .c_i          (ext_word[idx_hi][WORD_WIDTH-2:0]),
        .shift_size_i (s),
        .shift_type_i (RCR),
        .data_o       (shift_data)
    );

    assign cmd_ready_o = (state == IDLE);
    assign in_ready_o  = (state == LOAD);
    assign out_valid_o = (state == EMIT);
    assign out_last_o  = (state == EMIT) && last_idx;
    assign busy_o      = (state != IDLE);
    assign out_data_o  = (state == EMIT) ? shift_data : '0;

endmodule

// File: tb/tb_multiword_shift_r.sv
// tb/tb_multiword_shift_r.sv - self-checking bench for multiword_shift_r
module tb_multiword_shift_r;
    import multiword_shift_r_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_len;
    logic [4:0]  cmd_amount;
    shift_type_t cmd_type;
    logic [7:0]  cmd_fill;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiword_shift_r #(.WORD_WIDTH(8), .MAX_WORDS(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_len_i    (cmd_len),
        .cmd_amount_i (cmd_amount),
        .cmd_type_i   (cmd_type),
        .cmd_fill_i   (cmd_fill),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy)
    );

    typedef struct {
        int          len;
        int          amt;
        shift_type_t ty;
        logic [7:0]  fill;
        logic [31:0] words;
        logic [31:0] exp;
        int          stall;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Result = the operand, extended upward forever by the type's rule, read
    // as one long bit string starting at bit 'amount'.
    function automatic logic [31:0] model(input int len, input int amt, input shift_type_t ty,
                                          input logic [7:0] fill, input logic [31:0] words);
        int eff, span, a, src;
        logic [31:0] r;
        logic b;
        eff  = (len > 4) ? 4 : len;
        span = eff * 8;
        r    = '0;
        if (eff == 0) return r;
        a = (ty == ROR) ? (amt % span) : amt;
        for (int i = 0; i < span; i++) begin
            src = a + i;
            if (src < span)     b = words[src];
            else if (ty == LOGIC) b = 1'b0;
            else if (ty == ARITH) b = words[span-1];
            else if (ty == RCR)   b = fill[src % 8];
            else                  b = words[src % span];
            r[i] = b;
        end
        return r;
    endfunction

    task automatic run_op(input string nm, input int len, input int amt, input shift_type_t ty,
                          input logic [7:0] fill, input logic [31:0] words,
                          input int stall_idx, input logic [31:0] exp);
        int eff, lat, exp_lat, bound;
        logic [31:0] got;
        logic [7:0]  held;
        eff = (len > 4) ? 4 : len;
        @(negedge clk);
        chk({nm, ".cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_len    = len[2:0];
        cmd_amount = amt[4:0];
        cmd_type   = ty;
        cmd_fill   = fill;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (eff == 0) begin
            chk({nm, ".len0_idle"}, {30'b0, busy, cmd_ready}, 32'd1);
            return;
        end
        chk({nm, ".busy"}, {31'b0, busy}, 32'd1);
        for (int i = 0; i < eff; i++) begin
            in_valid = 1'b1;
            in_data  = words[8*i +: 8];
            bound = 0;
            while (!in_ready && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            if (!in_ready) chk({nm, ".in_timeout"}, 32'd0, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = 1 + ((ty == ROR) ? (amt / (eff * 8)) : 0);
        chk({nm, ".latency"}, lat, exp_lat);
        got = '0;
        for (int i = 0; i < eff; i++) begin
            bound = 0;
            while (!out_valid && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            chk({nm, ".out_valid"}, {31'b0, out_valid}, 32'd1);
            chk({nm, ".cmd_ready_busy"}, {31'b0, cmd_ready}, 32'd0);
            if (i == stall_idx) begin
                out_ready = 1'b0;
                held = out_data;
                repeat (3) begin
                    @(negedge clk);
                    chk({nm, ".stall_valid"}, {31'b0, out_valid}, 32'd1);
                    chk({nm, ".stall_data"}, {24'b0, out_data}, {24'b0, held});
                    chk({nm, ".stall_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
                end
                out_ready = 1'b1;
            end
            got[8*i +: 8] = out_data;
            chk({nm, ".last"}, {31'b0, out_last}, {31'b0, (i == eff - 1)});
            @(negedge clk);
        end
        chk({nm, ".data"}, got, exp);
        chk({nm, ".done"}, {30'b0, out_valid, busy}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4, 12, LOGIC, 8'h00, 32'h44332211, 32'h00044332, 1};
        vecs[1] = '{2,  4, ARITH, 8'h00, 32'h00008000, 32'h0000F800, -1};
        vecs[2] = '{2, 20, ROR,   8'h00, 32'h00001234, 32'h00004123, -1};
        vecs[3] = '{1,  4, RCR,   8'hAB, 32'h000000F0, 32'h000000BF, -1};
        vecs[4] = '{1,  9, RCR,   8'hAB, 32'h000000F0, 32'h000000D5, -1};
        vecs[5] = '{1, 12, LOGIC, 8'h5A, 32'h000000F0, 32'h00000000, -1};
        vecs[6] = '{3, 20, ARITH, 8'h00, 32'h00801234, 32'h00FFFFF8, -1};
        vecs[7] = '{1, 31, ROR,   8'h00, 32'h000000A5, 32'h0000004B, -1};
        vecs[8] = '{6,  0, LOGIC, 8'h00, 32'h44332211, 32'h44332211, 2};
        vecs[9] = '{4, 28, RCR,   8'hC3, 32'h11223344, 32'h3C3C3C31, -1};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_amount = '0;
        cmd_type   = LOGIC;
        cmd_fill   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.outputs", {26'b0, cmd_ready, in_ready, out_valid, out_last, busy, 1'b0}, 32'h20);
        chk("reset.out_data", {24'b0, out_data}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].len, vecs[v].amt, vecs[v].ty, vecs[v].fill,
                   vecs[v].words, vecs[v].stall, vecs[v].exp);
        end

        // Reset pulsed in the middle of loading abandons the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 3'd4; cmd_amount = 5'd8; cmd_type = LOGIC; cmd_fill = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.state", {28'b0, cmd_ready, in_ready, out_valid, busy}, 32'h8);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        run_op("after_rst", 4, 12, LOGIC, 8'h00, 32'h44332211, -1, 32'h00044332);
        run_op("len0", 0, 5, LOGIC, 8'h00, 32'h0, -1, 32'h0);
        run_op("after_len0", 2, 4, ARITH, 8'h00, 32'h00008000, -1, 32'h0000F800);

        for (int r = 0; r < 60; r++) begin
            int len, amt, st;
            shift_type_t ty;
            logic [7:0]  fill;
            logic [31:0] words;
            len   = $urandom_range(0, 6);
            amt   = $urandom_range(0, 31);
            ty    = shift_type_t'($urandom_range(0, 3));
            fill  = 8'($urandom);
            words = $urandom;
            st    = $urandom_range(0, 7) - 2;
            run_op($sformatf("rnd%0d", r), len, amt, ty, fill, words, st,
                   model(len, amt, ty, fill, words));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
